// File: rtl/nacc_engine.sv
// Multi-cycle neuron accumulator: LANES spike-gated weights per beat with per-beat
// signed saturation, followed by an optional leak and threshold/fire step.
module nacc_engine #(
    parameter int NUM_SYN   = 16,
    parameter int W_WIDTH   = 32,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [$clog2(NUM_SYN):0]     vl,
    input  logic [NUM_SYN-1:0]           spikes,
    input  logic [NUM_SYN*W_WIDTH-1:0]   weights,
    input  logic [ACC_WIDTH-1:0]         cur_in,
    input  logic [4:0]                   leak_shift,
    input  logic [ACC_WIDTH-1:0]         threshold,
    output logic                         busy,
    output logic                         done,
    output logic [ACC_WIDTH-1:0]         cur_out,
    output logic                         fired
);
    localparam int VL_W  = $clog2(NUM_SYN) + 1;
    localparam int SUM_W = ACC_WIDTH + $clog2(LANES) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_POST} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    mode_q, mode_d;
    logic [NUM_SYN-1:0]            spikes_q, spikes_d;
    logic [NUM_SYN-1:0]            valid_q, valid_d;
    logic [NUM_SYN*W_WIDTH-1:0]    weights_q, weights_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [4:0]                    leak_shift_q, leak_shift_d;
    logic signed [ACC_WIDTH-1:0]   threshold_q, threshold_d;
    logic                          done_q, done_d;
    logic [ACC_WIDTH-1:0]          cur_out_q, cur_out_d;
    logic                          fired_q, fired_d;

    logic [VL_W-1:0]               vl_c;
    logic [NUM_SYN-1:0]            vmask;
    logic signed [SUM_W-1:0]       lane_sum;
    logic signed [SUM_W-1:0]       acc_sum;
    logic signed [ACC_WIDTH-1:0]   acc_sat;
    logic signed [ACC_WIDTH-1:0]   leak_v;

    // Latched vectors are shifted down LANES synapses per beat, so lane j always
    // reads slot j; valid_q tracks the vl window and ends the accumulation.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        spikes_d     = spikes_q;
        valid_d      = valid_q;
        weights_d    = weights_q;
        acc_d        = acc_q;
        leak_shift_d = leak_shift_q;
        threshold_d  = threshold_q;
        done_d       = 1'b0;
        cur_out_d    = cur_out_q;
        fired_d      = fired_q;

        vl_c = (vl > VL_W'(NUM_SYN)) ? VL_W'(NUM_SYN) : vl;
        vmask = '0;
        for (int unsigned i = 0; i < NUM_SYN; i++) begin
            vmask[i] = (VL_W'(i) < vl_c);
        end

        lane_sum = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (spikes_q[j]) begin
                lane_sum = lane_sum +
                    {{(SUM_W-W_WIDTH){weights_q[j*W_WIDTH+W_WIDTH-1]}},
                     weights_q[j*W_WIDTH +: W_WIDTH]};
            end
        end
        acc_sum = {{(SUM_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q} + lane_sum;

        if ((&acc_sum[SUM_W-1:ACC_WIDTH-1]) || !(|acc_sum[SUM_W-1:ACC_WIDTH-1])) begin
            acc_sat = acc_sum[ACC_WIDTH-1:0];
        end else if (acc_sum[SUM_W-1]) begin
            acc_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            acc_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end

        if ((mode_q != 2'd0) && (leak_shift_q != 5'd0)) begin
            leak_v = acc_q - (acc_q >>> leak_shift_q);
        end else begin
            leak_v = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    spikes_d     = spikes & vmask;
                    valid_d      = vmask;
                    weights_d    = weights;
                    acc_d        = cur_in;
                    leak_shift_d = leak_shift;
                    threshold_d  = threshold;
                    state_d      = (vl_c != '0) ? S_ACCUM : S_POST;
                end
            end
            S_ACCUM: begin
                acc_d     = acc_sat;
                spikes_d  = spikes_q >> LANES;
                valid_d   = valid_q >> LANES;
                weights_d = weights_q >> (LANES*W_WIDTH);
                if ((valid_q >> LANES) == '0) begin
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (mode_q[1] && (leak_v >= threshold_q)) begin
                    fired_d   = 1'b1;
                    cur_out_d = '0;
                end else begin
                    fired_d   = 1'b0;
                    cur_out_d = leak_v;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            spikes_q     <= '0;
            valid_q      <= '0;
            weights_q    <= '0;
            acc_q        <= '0;
            leak_shift_q <= '0;
            threshold_q  <= '0;
            done_q       <= 1'b0;
            cur_out_q    <= '0;
            fired_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            spikes_q     <= spikes_d;
            valid_q      <= valid_d;
            weights_q    <= weights_d;
            acc_q        <= acc_d;
            leak_shift_q <= leak_shift_d;
            threshold_q  <= threshold_d;
            done_q       <= done_d;
            cur_out_q    <= cur_out_d;
            fired_q      <= fired_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign cur_out = cur_out_q;
    assign fired   = fired_q;

endmodule

// File: tb/tb_nacc_engine.sv
// Directed bench for nacc_engine: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_nacc_engine;
    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   mode;
    logic [4:0]   vl;
    logic [15:0]  spikes;
    logic [511:0] weights;
    logic [31:0]  cur_in;
    logic [4:0]   leak_shift;
    logic [31:0]  threshold;
    logic         busy, done, fired;
    logic [31:0]  cur_out;

    typedef struct {
        logic [31:0] cur;
        logic        fired;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    nacc_engine #(.NUM_SYN(16), .W_WIDTH(32), .LANES(4), .ACC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .vl(vl),
        .spikes(spikes), .weights(weights), .cur_in(cur_in),
        .leak_shift(leak_shift), .threshold(threshold),
        .busy(busy), .done(done), .cur_out(cur_out), .fired(fired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done cyc=%0d actual=1 required=0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("cur_out", {32'h0, cur_out}, {32'h0, mon_e.cur});
                chk("fired", {63'h0, fired}, {63'h0, mon_e.fired});
                chk("done_cycle", 64'(cyc), 64'(mon_e.due));
                chk("busy_at_done", {63'h0, busy}, 64'h0);
            end
        end
    end

    function automatic logic [511:0] w_fill(input logic [31:0] v);
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = v;
        return w;
    endfunction

    function automatic logic [511:0] w_inc();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = 32'(i + 1);
        return w;
    endfunction

    task automatic drive(input logic [1:0] m, input logic [4:0] v, input logic [15:0] s,
                         input logic [511:0] w, input logic [31:0] c, input logic [4:0] ls,
                         input logic [31:0] th);
        mode = m; vl = v; spikes = s; weights = w; cur_in = c; leak_shift = ls; threshold = th;
    endtask

    task automatic push(input logic [31:0] c, input logic f, input int due);
        exp_t e;
        e.cur = c; e.fired = f; e.due = due;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s cyc=%0d pending=%0d required=0", name, cyc, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [4:0] v, input logic [15:0] s,
                          input logic [511:0] w, input logic [31:0] c, input logic [4:0] ls,
                          input logic [31:0] th, input logic [31:0] exp_cur,
                          input logic exp_fired, input int b, input string name);
        @(negedge clk);
        drive(m, v, s, w, c, ls, th);
        start = 1'b1;
        push(exp_cur, exp_fired, cyc + b + 2);
        for (int k = 1; k <= b + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk({name, "_busy"}, {63'h0, busy}, 64'h1);
        end
        @(negedge clk);
        chk({name, "_busy_end"}, {63'h0, busy}, 64'h0);
        @(negedge clk);
        drain({name, "_drain"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] w;
        reset = 1'b1;
        start = 1'b0;
        drive(2'd0, 5'd0, 16'h0, '0, 32'h0, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_cur_out", {32'h0, cur_out}, 64'h0);
        chk("rst_fired", {63'h0, fired}, 64'h0);

        run_op(2'd0, 5'd16, 16'hFFFF, w_fill(32'd1), 32'd10, 5'd0, 32'd0, 32'd26, 1'b0, 4, "full");
        run_op(2'd0, 5'd5, 16'hFFFF, w_inc(), 32'd0, 5'd0, 32'd0, 32'd15, 1'b0, 2, "vl5");
        run_op(2'd0, 5'd5, 16'b10101, w_inc(), 32'd0, 5'd0, 32'd0, 32'd9, 1'b0, 2, "mask");
        run_op(2'd0, 5'd20, 16'hFFFF, w_fill(32'd1), 32'd0, 5'd0, 32'd0, 32'd16, 1'b0, 4, "clamp");
        run_op(2'd0, 5'd16, 16'h00F0, w_fill(32'hFFFFFFFD), 32'd5, 5'd0, 32'd0,
               32'hFFFFFFF9, 1'b0, 4, "neg");

        w = '0;
        w[31:0] = 32'h100;
        run_op(2'd0, 5'd1, 16'h0001, w, 32'h7FFFFFF0, 5'd0, 32'd0, 32'h7FFFFFFF, 1'b0, 1, "sat_pos");
        w[31:0] = 32'hFFFFFF00;
        run_op(2'd0, 5'd1, 16'h0001, w, 32'h80000010, 5'd0, 32'd0, 32'h80000000, 1'b0, 1, "sat_neg");
        w = '0;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = 32'h100;
        for (int i = 4; i < 8; i++) w[i*32 +: 32] = 32'hFFFFFF00;
        run_op(2'd0, 5'd8, 16'h00FF, w, 32'h7FFFFFF0, 5'd0, 32'd0, 32'h7FFFFBFF, 1'b0, 2, "sat_beat");

        run_op(2'd1, 5'd0, 16'h0, '0, 32'd100, 5'd2, 32'd0, 32'd75, 1'b0, 0, "leak");
        run_op(2'd1, 5'd0, 16'h0, '0, 32'd100, 5'd0, 32'd0, 32'd100, 1'b0, 0, "leak_off");
        run_op(2'd0, 5'd0, 16'h0, '0, 32'd100, 5'd2, 32'd0, 32'd100, 1'b0, 0, "mode0");
        run_op(2'd2, 5'd0, 16'h0, '0, 32'd100, 5'd2, 32'd80, 32'd75, 1'b0, 0, "nofire");
        run_op(2'd2, 5'd0, 16'h0, '0, 32'd100, 5'd2, 32'd70, 32'd0, 1'b1, 0, "fire");
        run_op(2'd2, 5'd0, 16'h0, '0, 32'hFFFFFF9C, 5'd2, 32'hFFFFFF38, 32'd0, 1'b1, 0, "fire_neg");
        run_op(2'd3, 5'd0, 16'h0, '0, 32'd100, 5'd0, 32'd100, 32'd0, 1'b1, 0, "fire_eq");

        // second start while busy must be ignored
        @(negedge clk);
        drive(2'd0, 5'd16, 16'hFFFF, w_fill(32'd1), 32'd10, 5'd0, 32'd0);
        start = 1'b1;
        push(32'd26, 1'b0, cyc + 6);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        drive(2'd0, 5'd16, 16'h000F, w_fill(32'd7), 32'd999, 5'd0, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        drain("ignore_drain");

        // start held across done: back-to-back ops, later inputs latched by the second
        @(negedge clk);
        drive(2'd0, 5'd16, 16'hFFFF, w_fill(32'd1), 32'd10, 5'd0, 32'd0);
        start = 1'b1;
        push(32'd26, 1'b0, cyc + 6);
        repeat (3) @(negedge clk);
        cur_in = 32'd100;
        push(32'd116, 1'b0, cyc + 9);
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        drain("b2b_drain");

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        drive(2'd0, 5'd16, 16'hFFFF, w_fill(32'd1), 32'd10, 5'd0, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", {63'h0, busy}, 64'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_cur_out", {32'h0, cur_out}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        drain("abort_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
